// File: rtl/alu_wide_seq_pkg.sv
// Shared types and constants for the multi-precision alu sequencer.
//  ALU_W    : datapath width of the attached 16-bit alu
//  state_e  : sequencer FSM states
//  OP_*     : alu select codes whose carry chaining gives exact wide results
//             (OP_XOR is a logic-mode op, exact per slice)
package alu_wide_seq_pkg;
  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_INC = 4'b0000;  // A + cin
  localparam logic [3:0] OP_ADD = 4'b1001;  // A + B + cin
  localparam logic [3:0] OP_DBL = 4'b1100;  // A + A + cin
  localparam logic [3:0] OP_XOR = 4'b0110;  // A ^ B (logic mode)
endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response bus of the wide alu sequencer.
//  master : requester side (drives req_*, rsp_ready)
//  slave  : sequencer side (drives req_ready, rsp_*)
interface alu_wide_seq_if
  import alu_wide_seq_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int WORDS = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [W*WORDS-1:0] req_a;
  logic [W*WORDS-1:0] req_b;
  logic [3:0]         req_sel;
  logic               req_mode;
  logic               req_carry_in;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [W*WORDS-1:0] rsp_result;
  logic               rsp_carry;
  logic               rsp_equal;
  logic               rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_mode, req_carry_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_equal, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_mode, req_carry_in, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_equal, rsp_zero
  );
endinterface

// File: rtl/alu_wide_seq.sv
// Multi-precision sequencer for a 16-bit alu.
// Takes one W*WORDS-bit op over bus (valid/ready), walks the alu through the
// operand one W-bit slice per cycle (LS slice first), chaining alu carry_out
// into the next slice's carry_in, then returns the wide result, final carry,
// whole-operand equality and a zero flag over bus.
//  clk, rst       : single clock, synchronous active-high reset
//  bus            : request/response bus (slave modport)
//  alu_in_a/b     : current slice of A/B to the alu (0 outside RUN)
//  alu_sel/mode   : held op select/mode (0 outside RUN)
//  alu_carry_in   : request carry on slice 0, chained carry after
//  alu_out, alu_carry_out, alu_compare : combinational alu results
module alu_wide_seq
  import alu_wide_seq_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_wide_seq_if.slave bus,
  output logic [W-1:0]  alu_in_a,
  output logic [W-1:0]  alu_in_b,
  output logic [3:0]    alu_sel,
  output logic          alu_mode,
  output logic          alu_carry_in,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_carry_out,
  input  logic          alu_compare
);
  localparam int              IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [WORDS-1:0][W-1:0] a_q, b_q, res_q, res_d;
  logic [3:0]              sel_q;
  logic                    mode_q, cin_q, carry_q, eq_q, zero_q;
  logic                    accept, run, last;

  assign accept = bus.req_valid && bus.req_ready;
  assign run    = (state_q == RUN);
  assign last   = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_in_a      = '0;
    alu_in_b      = '0;
    alu_sel       = '0;
    alu_mode      = 1'b0;
    alu_carry_in  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = RUN;
      end
      RUN: begin
        alu_in_a     = a_q[idx_q];
        alu_in_b     = b_q[idx_q];
        alu_sel      = sel_q;
        alu_mode     = mode_q;
        alu_carry_in = (idx_q == '0) ? cin_q : carry_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result with the current alu slice merged in; used both for the capture
  // and for the zero flag on the final slice.
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = alu_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.req_a;
      b_q    <= bus.req_b;
      sel_q  <= bus.req_sel;
      mode_q <= bus.req_mode;
      cin_q  <= bus.req_carry_in;
      idx_q  <= '0;
      eq_q   <= 1'b1;
    end else if (run) begin
      res_q   <= res_d;
      carry_q <= alu_carry_out;
      eq_q    <= eq_q & alu_compare;
      idx_q   <= idx_q + 1'b1;
      if (last) zero_q <= (res_d == '0);
    end
  end

  assign bus.rsp_result = res_q;
  // Logic-mode carry has no meaning across slices; report 0.
  assign bus.rsp_carry  = carry_q & ~mode_q;
  assign bus.rsp_equal  = eq_q;
  assign bus.rsp_zero   = zero_q;
endmodule

// File: tb/tb_alu_wide_seq.sv
module tb_alu_wide_seq;
  import alu_wide_seq_pkg::*;

  localparam int W = 16, WORDS = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  alu_wide_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  logic [W-1:0] alu_in_a, alu_in_b, alu_out;
  logic [3:0]   alu_sel;
  logic         alu_mode, alu_carry_in, alu_carry_out, alu_compare;

  alu_wide_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_sel(alu_sel),
    .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare)
  );

  // Behavioural 16-bit alu covering the ops exercised here.
  logic [W:0] sum;
  always_comb begin
    sum = '0;
    if (!alu_mode) begin
      case (alu_sel)
        OP_ADD:  sum = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{W{1'b0}}, alu_carry_in};
        OP_DBL:  sum = {1'b0, alu_in_a} + {1'b0, alu_in_a} + {{W{1'b0}}, alu_carry_in};
        default: sum = {1'b0, alu_in_a} + {{W{1'b0}}, alu_carry_in};
      endcase
    end else begin
      case (alu_sel)
        OP_XOR:  sum = {1'b0, alu_in_a ^ alu_in_b};
        default: sum = {1'b0, alu_in_a & alu_in_b};
      endcase
    end
  end
  assign alu_out       = sum[W-1:0];
  assign alu_carry_out = sum[W];
  assign alu_compare   = (alu_in_a == alu_in_b);

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Presents an op and returns #1 after the accepting posedge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel,
                          input logic mode, input logic cin);
    int t;
    @(negedge clk);
    bus.req_a = a; bus.req_b = b; bus.req_sel = sel;
    bus.req_mode = mode; bus.req_carry_in = cin; bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 32) begin @(negedge clk); t++; end
    if (t >= 32) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Called #1 after accept; counts posedges to rsp_valid, logs carry_in per slice.
  task automatic wait_rsp(output int lat, output logic [3:0] ci);
    ci    = '0;
    ci[0] = alu_carry_in;
    lat   = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.rsp_valid && lat < 4) ci[lat] = alu_carry_in;
    end
    if (!bus.rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic pop_rsp();
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
  endtask

  int          lat;
  logic [3:0]  ci;
  logic [63:0] held;
  int          seen;

  initial begin
    bus.req_valid = 0; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0;
    bus.req_mode = 0; bus.req_carry_in = 0; bus.rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_flags", {bus.rsp_carry, bus.rsp_equal, bus.rsp_zero}, 3'b000);
    chk("rst_alu_idle", {alu_in_a, alu_sel, alu_carry_in}, '0);

    // 1: carry ripples out of slice 0 only
    start_op(64'h0000_0000_0000_FFFF, 64'd1, OP_ADD, 1'b0, 1'b0);
    wait_rsp(lat, ci);
    chk("t1_latency", lat, 4);
    chk("t1_result", bus.rsp_result, 64'h0000_0000_0001_0000);
    chk("t1_carry", bus.rsp_carry, 1'b0);
    chk("t1_zero_eq", {bus.rsp_zero, bus.rsp_equal}, 2'b00);
    chk("t1_cin_chain", ci, 4'b0010);
    pop_rsp();

    // 2: full-width overflow
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, 1'b0);
    wait_rsp(lat, ci);
    chk("t2_result", bus.rsp_result, 64'd0);
    chk("t2_carry", bus.rsp_carry, 1'b1);
    chk("t2_zero", bus.rsp_zero, 1'b1);
    pop_rsp();

    // 3: logic xor of equal operands
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OP_XOR, 1'b1, 1'b0);
    wait_rsp(lat, ci);
    chk("t3_result", bus.rsp_result, 64'd0);
    chk("t3_flags", {bus.rsp_equal, bus.rsp_carry, bus.rsp_zero}, 3'b101);
    pop_rsp();

    // 4: response backpressure with a new request held
    start_op(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, OP_ADD, 1'b0, 1'b0);
    wait_rsp(lat, ci);
    held = bus.rsp_result;
    chk("t4_result", held, 64'h2222_3333_4444_5555);
    @(negedge clk);
    bus.req_a = 64'd5; bus.req_b = 64'd3; bus.req_sel = OP_ADD;
    bus.req_mode = 0; bus.req_carry_in = 0; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_result", bus.rsp_result, held);
      chk("t4_hold_state", {bus.rsp_valid, bus.req_ready}, 2'b10);
    end
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    chk("t4_after_pop", {bus.rsp_valid, bus.req_ready}, 2'b01);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    chk("t4_accepted", bus.req_ready, 1'b0);
    wait_rsp(lat, ci);
    chk("t4_second_lat", lat, 4);
    chk("t4_second_result", bus.rsp_result, 64'd8);
    pop_rsp();

    // 5: reset while idx==2 drops the op
    start_op(64'h0000_0000_0000_FFFF, 64'd1, OP_ADD, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_req_ready", bus.req_ready, 1'b1);
    chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t5_result_clr", bus.rsp_result, 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    chk("t5_no_rsp", seen, 0);

    // 6: increment with carry-in ripples through every slice
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, OP_INC, 1'b0, 1'b1);
    wait_rsp(lat, ci);
    chk("t6_result", bus.rsp_result, 64'd0);
    chk("t6_carry", bus.rsp_carry, 1'b1);
    chk("t6_cin_all", ci, 4'b1111);
    pop_rsp();

    // doubling: 0x8000_0000_0000_0001 * 2 = 2, carry 1
    start_op(64'h8000_0000_0000_0001, 64'd0, OP_DBL, 1'b0, 1'b0);
    wait_rsp(lat, ci);
    chk("dbl_result", bus.rsp_result, 64'd2);
    chk("dbl_carry", bus.rsp_carry, 1'b1);
    pop_rsp();
    chk("idle_alu_zero", {alu_in_a, alu_in_b, alu_sel, alu_mode, alu_carry_in}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
